nstate_step_ctrl: RTL

- Sequential companion to the combinational next-state decoder: holds the current 4-bit game state and drives it as the decoder's X input.
- Synchronizes the move switches, drives them as the decoder's Y input, and commits the decoder's Out result on each debounced press of the step button.
- Sits between board I/O (button, switches) and the decoder; its state output also feeds the display logic.

---
 rtl/nstate_pkg.sv | 24 ++
 rtl/nstate_step_ctrl_btn_debounce.sv | 46 ++++
 rtl/nstate_step_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/nstate_pkg.sv
// Shared types for the step controller that sequences the next-state decoder.
// Widths, the controller FSM encoding and a saturating step-count helper.
package nstate_pkg;

  localparam int STATE_W = 4;
  localparam int MOVE_W  = 2;
  localparam int CNT_W   = 8;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [MOVE_W-1:0]  move_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RELEASE = 2'd2
  } ctrl_fsm_t;

  // Step counter holds at all-ones rather than wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/nstate_step_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one pushbutton.
// level_o follows the synchronized input only after it has held a new value long enough.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the input disagrees with the debounced level;
  // any agreement (a bounce back) clears it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/nstate_step_ctrl.sv
// Holds the game state fed to the next-state decoder and commits the decoder
// result once per debounced step press; rejects results above MAX_STATE.
module nstate_step_ctrl
  import nstate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_STATE       = 8,
  parameter int TERMINAL_STATE  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_btn,
  input  logic [1:0] move_sw,
  input  logic [3:0] next_state,
  output logic [3:0] state,
  output logic [1:0] move,
  output logic [7:0] step_count,
  output logic       done,
  output logic       illegal
);

  localparam state_t MAX_S  = state_t'(MAX_STATE);
  localparam state_t TERM_S = state_t'(TERMINAL_STATE);

  ctrl_fsm_t fsm_q, fsm_d;
  state_t    state_q, state_d;
  move_t     move_q, move_d;
  move_t     msync1_q, msync2_q;
  cnt_t      cnt_q, cnt_d;
  logic      done_q, done_d;
  logic      illegal_q, illegal_d;
  logic      btn_lvl, btn_prev_q, press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbnc (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (step_btn),
    .level_o (btn_lvl)
  );

  assign press = btn_lvl & ~btn_prev_q;

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    move_d    = move_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    done_d    = done_q | (state_q == TERM_S);
    case (fsm_q)
      IDLE: begin
        if (press) begin
          if (done_q) begin
            fsm_d = RELEASE;
          end else begin
            move_d = msync2_q;
            fsm_d  = EVAL;
          end
        end
      end
      // move_q was latched last cycle, so the decoder output now matches it.
      EVAL: begin
        if (next_state <= MAX_S) begin
          state_d = next_state;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          illegal_d = 1'b1;
        end
        fsm_d = RELEASE;
      end
      RELEASE: begin
        if (!btn_lvl) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      move_q     <= '0;
      msync1_q   <= '0;
      msync2_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      move_q     <= move_d;
      msync1_q   <= move_sw;
      msync2_q   <= msync1_q;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      btn_prev_q <= btn_lvl;
    end
  end

  assign state      = state_q;
  assign move       = move_q;
  assign step_count = cnt_q;
  assign done       = done_q;
  assign illegal    = illegal_q;

endmodule
